// File: rtl/fft_sdf_stage.sv
// ----------------------------------------------------------------------------
// fft_sdf_stage
//
// Radix-2 single-delay-feedback butterfly stage for a pipelined FFT. LANES
// independent complex streams share one sample counter. Each stream has a
// DEPTH-deep feedback delay per real/imag component.
//
// Frame timing (frame length 2*DEPTH samples):
//   - Fill phase: the first DEPTH samples are pushed into the delay. The delay
//     head, which holds the previous frame's differences, goes to the output.
//   - Butterfly phase: the next DEPTH samples meet the stored fill samples. The
//     sums are output and the differences are pushed into the delay.
// Output order within a frame is DEPTH sums (idx 0..DEPTH-1), followed by
// DEPTH differences (idx DEPTH..2*DEPTH-1). The differences appear during the
// next frame's fill phase.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   in_valid  a sample is present on all lanes this cycle
//   in_sof    qualified by in_valid; this sample is sample 0 of a frame
//   scale_en  1 = halve the butterfly results (floor); sampled at sample 0
//   in_data   lane k at [(k+1)*2*NBITS-1 : k*2*NBITS], {re, im}
//   out_valid an output sample is present
//   out_sof   first output sample of a frame (the first sum)
//   out_idx   index of the output sample within its frame
//   out_data  same packing as in_data, with NBITS+1 wide components
// ----------------------------------------------------------------------------
module fft_sdf_stage #(
    parameter int NBITS = 10,
    parameter int DEPTH = 16,
    parameter int LANES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_sof,
    input  logic                            scale_en,
    input  logic [LANES*2*NBITS-1:0]        in_data,
    output logic                            out_valid,
    output logic                            out_sof,
    output logic [$clog2(2*DEPTH)-1:0]      out_idx,
    output logic [LANES*2*(NBITS+1)-1:0]    out_data
);

    localparam int CW  = $clog2(2*DEPTH);
    localparam int AW  = $clog2(DEPTH);
    localparam int OW  = NBITS + 1;
    localparam int NCH = LANES * 2;

    localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(2*DEPTH - 1);

    // ------------------------------------------------------------------
    // Shared control path
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_cur;        // position of the sample being accepted
    logic          have_diff_reg;  // delay holds differences that must be emitted
    logic          have_diff_cur;
    logic          scale_q_reg;
    logic          abort;
    logic          phase;
    logic          emit;
    logic [AW-1:0] ptr_reg;

    // An in_sof in the middle of a frame restarts the count. The differences
    // already in the delay belong to an incomplete frame, so they are dropped.
    assign abort         = in_valid & in_sof & (cnt_reg != '0);
    assign cnt_cur       = (in_valid & in_sof) ? '0 : cnt_reg;
    assign phase         = cnt_cur[CW-1];
    assign have_diff_cur = have_diff_reg & ~abort;
    assign emit          = phase | have_diff_cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            have_diff_reg <= 1'b0;
            scale_q_reg   <= 1'b0;
            ptr_reg       <= '0;
        end else if (in_valid) begin
            cnt_reg       <= cnt_cur + CW'(1);
            have_diff_reg <= (cnt_cur == CNT_LAST) ? 1'b1 : have_diff_cur;
            if (cnt_cur == '0) begin
                scale_q_reg <= scale_en;
            end
            ptr_reg       <= ptr_reg + AW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-component datapath (one instance per real/imag component per lane)
    // ------------------------------------------------------------------
    logic [NCH*OW-1:0] res_all;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic [OW-1:0] mem [DEPTH];
        logic [OW-1:0] head_reg;
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic [OW:0]   sum_full;
        logic [OW:0]   diff_full;
        logic [OW-1:0] sum_sel;
        logic [OW-1:0] diff_sel;
        logic [OW-1:0] push;
        logic [OW-1:0] res;

        assign a = head_reg;
        assign b = {in_data[gi*NBITS + NBITS - 1], in_data[gi*NBITS +: NBITS]};

        // One extra bit of headroom, so the /2 path is a plain arithmetic shift.
        assign sum_full  = {a[OW-1], a} + {b[OW-1], b};
        assign diff_full = {a[OW-1], a} - {b[OW-1], b};
        assign sum_sel   = scale_q_reg ? sum_full[OW:1]  : sum_full[OW-1:0];
        assign diff_sel  = scale_q_reg ? diff_full[OW:1] : diff_full[OW-1:0];

        always_comb begin
            res  = head_reg;
            push = b;
            if (phase) begin
                res  = sum_sel;
                push = diff_sel;
            end
        end

        // The delay is a circular buffer. The slot written this cycle is the
        // oldest entry. The entry after it becomes the head at the next
        // accepted sample, so it is prefetched into a register. That keeps the
        // RAM read synchronous. DEPTH >= 2 guarantees that the read address
        // differs from the write address.
        always_ff @(posedge clk) begin
            if (in_valid) begin
                mem[ptr_reg] <= push;
                head_reg     <= mem[ptr_reg + AW'(1)];
            end
        end

        assign res_all[gi*OW +: OW] = res;
    end

    // ------------------------------------------------------------------
    // Registered outputs. Data, sof and idx change only with a valid output.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else if (in_valid) begin
            out_valid <= emit;
            if (emit) begin
                out_sof  <= (cnt_cur == CNT_HALF);
                out_idx  <= cnt_cur - CNT_HALF;
                out_data <= res_all;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// ----------------------------------------------------------------------------
// tb_fft_sdf_stage
//
// Directed test of fft_sdf_stage with NBITS=10, DEPTH=4 and LANES=2.
// Inputs change 1 ns after each rising edge. The registered outputs are
// sampled 1 ns after the edge that accepted the sample.
// ----------------------------------------------------------------------------
module tb_fft_sdf_stage;

    localparam int NBITS = 10;
    localparam int DEPTH = 4;
    localparam int LANES = 2;
    localparam int OW    = NBITS + 1;

    logic                         clk;
    logic                         rst;
    logic                         in_valid;
    logic                         in_sof;
    logic                         scale_en;
    logic [LANES*2*NBITS-1:0]     in_data;
    logic                         out_valid;
    logic                         out_sof;
    logic [2:0]                   out_idx;
    logic [LANES*2*OW-1:0]        out_data;

    int checks = 0;
    int errors = 0;

    fft_sdf_stage #(.NBITS(NBITS), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .scale_en (scale_en),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_sof  (out_sof),
        .out_idx  (out_idx),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-state return, so an X on the output stays visible to !==.
    function automatic integer lane_re(input int k);
        return $signed(out_data[(2*k+1)*OW +: OW]);
    endfunction

    function automatic integer lane_im(input int k);
        return $signed(out_data[(2*k)*OW +: OW]);
    endfunction

    // Applies one cycle of inputs, then samples 1 ns after the edge.
    task automatic drive(input bit v, input bit sof, input bit sc,
                         input int r0, input int i0, input int r1, input int i1);
        in_valid = v;
        in_sof   = sof;
        scale_en = sc;
        in_data  = {10'(r1), 10'(i1), 10'(r0), 10'(i0)};
        @(posedge clk);
        #1;
        $display("in v=%0b sof=%0b sc=%0b re0=%0d re1=%0d | out v=%0b sof=%0b idx=%0d re0=%0d im0=%0d re1=%0d",
                 v, sof, sc, r0, r1, out_valid, out_sof, out_idx,
                 lane_re(0), lane_im(0), lane_re(1));
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        scale_en = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        scale_en = 1'b1;
        in_data  = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b required 0", out_valid);
        end
        checks++;
        if (out_sof !== 1'b0) begin
            errors++;
            $display("FAIL reset_sof: got %0b required 0", out_sof);
        end
        checks++;
        if (out_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d required 0", out_idx);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", out_data);
        end
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, s == 0, 1'b0, s + 1, s + 1, -s, 0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_first_samples s=%0d: got valid %0b required 0", s, out_valid);
            end
        end
    endtask

    // Ramp stimulus: lane0 re=k, im=1; lane1 re=-k, im=0, for 2.5 frames.
    // Sums are (k-4)+k = 2k-4 and im 1+1 = 2. Differences are -4 and im 0.
    task automatic run_ramp(input bit gaps, input string tag);
        int  k;
        bit  ev;
        bit  es;
        int  ei;
        int  er0;
        int  ei0;
        int  er1;
        int  ng;
        apply_reset();
        for (int s = 0; s < 20; s++) begin
            k = s % 8;
            if (gaps) begin
                ng = $urandom_range(0, 2);
                for (int g = 0; g < ng; g++) begin
                    drive(1'b0, 1'b1, 1'b1, 77, 77, 77, 77);
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s gap before s=%0d: got valid %0b required 0", tag, s, out_valid);
                    end
                end
            end
            drive(1'b1, k == 0, 1'b0, k, 1, -k, 0);
            ev = !(s < 8 && k < 4);
            if (k >= 4) begin
                es = (k == 4); ei = k - 4; er0 = 2*k - 4; ei0 = 2; er1 = -(2*k - 4);
            end else begin
                es = 1'b0; ei = 4 + k; er0 = -4; ei0 = 0; er1 = 4;
            end
            checks++;
            if (out_valid !== ev ||
                (ev && (out_sof !== es || out_idx !== 3'(ei) || lane_re(0) !== er0 ||
                        lane_im(0) !== ei0 || lane_re(1) !== er1))) begin
                errors++;
                $display("FAIL %s s=%0d: got v=%0b sof=%0b idx=%0d re0=%0d im0=%0d re1=%0d required v=%0b sof=%0b idx=%0d re0=%0d im0=%0d re1=%0d",
                         tag, s, out_valid, out_sof, out_idx, lane_re(0), lane_im(0), lane_re(1),
                         ev, es, ei, er0, ei0, er1);
            end
        end
    endtask

    task automatic test_basic();
        run_ramp(1'b0, "basic");
    endtask

    task automatic test_gaps();
        run_ramp(1'b1, "gaps");
    endtask

    // ------------------------------------------------------------------
    // Frames: F0 all -512, F1 511x4/-512x4 (both unscaled), F2 and F3 the
    // same pair scaled, and F4 a fill frame that flushes F3's differences.
    task automatic test_extremes();
        int fill_exp [5] = '{0, 0, 1023, 0, 511};
        int sum_exp  [5] = '{-1024, -1, -512, -1, 0};
        int f;
        int k;
        int x;
        bit sc;
        bit ev;
        int ei;
        int er;
        apply_reset();
        for (int s = 0; s < 36; s++) begin
            f  = s / 8;
            k  = s % 8;
            sc = (f == 2 || f == 3);
            if (f == 4)          x = 0;
            else if (f % 2 == 0) x = -512;
            else                 x = (k < 4) ? 511 : -512;
            drive(1'b1, k == 0, sc, x, 0, 0, 0);
            ev = (k < 4) ? (f >= 1) : 1'b1;
            ei = (k < 4) ? 4 + k : k - 4;
            er = (k < 4) ? fill_exp[f] : sum_exp[f];
            checks++;
            if (out_valid !== ev ||
                (ev && (out_idx !== 3'(ei) || lane_re(0) !== er || lane_re(1) !== 0))) begin
                errors++;
                $display("FAIL extremes f=%0d k=%0d: got v=%0b idx=%0d re0=%0d re1=%0d required v=%0b idx=%0d re0=%0d re1=0",
                         f, k, out_valid, out_idx, lane_re(0), lane_re(1), ev, ei, er);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // x = {3,-3,3,-3,0,0,0,0}. F0 is scaled (scale_en drops mid-frame, which
    // has no effect), F1 is unscaled (scale_en rises mid-frame, which has no
    // effect), and F2 flushes F1's differences.
    task automatic test_scale_floor();
        int xs [8] = '{3, -3, 3, -3, 0, 0, 0, 0};
        int sum_exp  [3][4] = '{'{1, -2, 1, -2}, '{3, -3, 3, -3}, '{0, 0, 0, 0}};
        int fill_exp [3][4] = '{'{0, 0, 0, 0}, '{1, -2, 1, -2}, '{3, -3, 3, -3}};
        int f;
        int k;
        bit sc;
        bit ev;
        int er;
        apply_reset();
        for (int s = 0; s < 20; s++) begin
            f = s / 8;
            k = s % 8;
            if (f == 0)      sc = (k < 2);
            else if (f == 1) sc = (k >= 1);
            else             sc = 1'b0;
            drive(1'b1, k == 0, sc, (f == 2) ? 0 : xs[k], 0, 0, 0);
            ev = (k < 4) ? (f >= 1) : 1'b1;
            er = (k < 4) ? fill_exp[f][k] : sum_exp[f][k-4];
            checks++;
            if (out_valid !== ev || (ev && lane_re(0) !== er)) begin
                errors++;
                $display("FAIL scale f=%0d k=%0d: got v=%0b re0=%0d required v=%0b re0=%0d",
                         f, k, out_valid, lane_re(0), ev, er);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checks a fresh frame with input base+k. No output appears during the
    // fill phase, then sums 2*base+2k-4 appear with out_sof on idx 0.
    task automatic check_resync(input int base, input string tag);
        bit ev;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k == 0, 1'b0, base + k, 0, 0, 0);
            ev = (k >= 4);
            checks++;
            if (out_valid !== ev ||
                (ev && (out_sof !== (k == 4) || out_idx !== 3'(k - 4) ||
                        lane_re(0) !== 2*base + 2*k - 4))) begin
                errors++;
                $display("FAIL %s k=%0d: got v=%0b sof=%0b idx=%0d re0=%0d required v=%0b sof=%0b idx=%0d re0=%0d",
                         tag, k, out_valid, out_sof, out_idx, lane_re(0),
                         ev, (k == 4), k - 4, 2*base + 2*k - 4);
            end
        end
    endtask

    task automatic test_abort_resync();
        apply_reset();
        // Frame 0: ramp 0..7, then 2 samples of frame 1 that emit diffs -4.
        for (int k = 0; k < 8; k++) drive(1'b1, k == 0, 1'b0, k, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, k == 0, 1'b0, k, 0, 0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(4 + k) || lane_re(0) !== -4) begin
                errors++;
                $display("FAIL abort_pre k=%0d: got v=%0b idx=%0d re0=%0d required v=1 idx=%0d re0=-4",
                         k, out_valid, out_idx, lane_re(0), 4 + k);
            end
        end
        // in_sof at cnt=2 aborts frame 1.
        check_resync(10, "abort");
        // The new frame completed, so the next fill emits its differences (-4).
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, k == 0, 1'b0, 0, 0, 0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_sof !== 1'b0 || out_idx !== 3'(4 + k) || lane_re(0) !== -4) begin
                errors++;
                $display("FAIL abort_post k=%0d: got v=%0b sof=%0b idx=%0d re0=%0d required v=1 sof=0 idx=%0d re0=-4",
                         k, out_valid, out_sof, out_idx, lane_re(0), 4 + k);
            end
        end
        // Asynchronous reset mid-frame, between clock edges.
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_idx !== 3'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b sof=%0b idx=%0d data=%h required all 0",
                     out_valid, out_sof, out_idx, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        check_resync(20, "reset_resync");
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        scale_en = 1'b0;
        in_data  = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_extremes();
        test_scale_floor();
        test_abort_resync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
